uart_tx: RTL
============

# uart_tx

Serial UART transmitter that is the counterpart of the team's `uart_rx`. It accepts bytes from user logic over a valid/ready handshake and buffers them in a small internal FIFO. Each byte is serialised as a standard 8N1 frame, LSB first, on the UART line. The block runs on the same baud-multiple clock as `uart_rx`, so one bit lasts exactly `BAUD_MULT` clocks.

## Interface
- `BAUD_MULT`, 139: clocks per bit (16 MHz / 139 ≈ 115200 baud); legal range ≥ 2.
- `FIFO_DEPTH_LOG2`, 2: FIFO holds 2^`FIFO_DEPTH_LOG2` bytes; legal range ≥ 1.

- `i_uart_clk`  in  1: sole clock; all logic on rising edge.
- `i_reset_n`  in  1: reset, synchronous, active-low.
- `i_tx_data`  in  8: byte to queue.
- `i_tx_valid`  in  1: `i_tx_data` is valid.
- `o_tx_ready`  out  1: FIFO can accept a byte (= not full).
- `o_tx`  out  1: serial line; idle high.
- `o_tx_active`  out  1: a frame (start/data/stop) is being driven.
- `o_fifo_count`  out  `FIFO_DEPTH_LOG2`+1: bytes queued, excluding the byte currently being shifted.
- `o_dbg_state`  out  1: high when the FSM is in IDLE.

## Operation
- Reset (`i_reset_n` low at a clock edge) applies after that edge, overriding everything:
  - `o_tx`=1, `o_tx_active`=0, `o_tx_ready`=1, `o_fifo_count`=0, `o_dbg_state`=1.
  - FIFO pointers cleared; bit and baud counters = 0; state = IDLE.
  - Any frame in progress is abandoned and the line returns high immediately. A partial frame is acceptable.
- FIFO write: a byte is stored on an edge where `i_tx_valid && o_tx_ready`.
  - `o_tx_ready` = (`o_fifo_count` != depth), driven combinationally from count.
  - No write while full, even if a pop occurs the same cycle.
- FIFO read/write on the same edge: the count is unchanged and the data stays ordered.
- Pointers are `FIFO_DEPTH_LOG2` bits wide and wrap naturally. The count is 1 bit wider so that full and empty can be told apart.
- FSM states:
  - IDLE: `o_tx`=1, `o_tx_active`=0. If FIFO is non-empty, pop the head into the shift register, set baud counter=0, set `o_tx`=0, and go to SEND_START.
  - SEND_START: `o_tx`=0 for `BAUD_MULT` clocks. On counter=`BAUD_MULT`-1: counter=0, bit count=0, `o_tx`=shift[0], go to SEND_DATA.
  - SEND_DATA: each bit is held `BAUD_MULT` clocks. At counter=`BAUD_MULT`-1, shift right by one and advance the bit count.
    - After bit 7 completes, `o_tx`=1 and go to SEND_STOP.
    - Otherwise `o_tx`=next bit.
  - SEND_STOP: `o_tx`=1 for `BAUD_MULT` clocks. On the final clock:
    - If the FIFO is non-empty, pop and go directly to SEND_START with `o_tx`=0; no idle gap.
    - Otherwise go to IDLE.
  - Illegal state encoding → IDLE with outputs at their reset values.
- `o_tx_active` is 1 in SEND_START, SEND_DATA and SEND_STOP.
- The baud counter is sized to hold `BAUD_MULT`-1 and never overflows.

## Timing
- All outputs are registered except `o_tx_ready` and `o_dbg_state`, which decode registered state.
- Latency: for a byte accepted at edge E0 with the FSM idle, `o_tx` falls after edge E0+1 (one clock).
- Frame length is exactly 10×`BAUD_MULT` clocks, from the start-bit falling edge to the end of the stop bit.
- Back-to-back frames have no extra idle clocks between the stop bit and the next start bit.
- The FIFO pop happens on the same edge that loads the start bit.
  - `o_fifo_count` decrements on that edge.
  - `o_tx_ready` can rise on that edge.
- Reset released at edge R: the first write can be accepted at edge R+1.

## Test plan
- Single byte, `BAUD_MULT`=4:
  - Stimulus: write 0x55 while idle.
  - Required `o_tx` after one clock: 0 for 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then 1 for 4 clocks.
  - `o_tx_active` is high for exactly 40 clocks, then `o_dbg_state`=1.
- Back-to-back:
  - Stimulus: write 0xA5 and 0x3C on consecutive clocks.
  - Required: two frames, 80 clocks total, with no idle clock between them.
  - A bench `uart_rx` instance decodes 0xA5 then 0x3C.
- FIFO full, `FIFO_DEPTH_LOG2`=2:
  - Stimulus: hold `i_tx_valid` for 6 clocks with data 0x01..0x06.
  - The first byte is popped immediately. `o_tx_ready` drops when `o_fifo_count`=4, and 0x06 is not accepted while `o_tx_ready` is low.
  - Line output is 0x01..0x05 in order.
- Simultaneous push/pop:
  - Stimulus: write a byte on the exact edge the stop bit ends, with the FIFO non-empty.
  - Required: count unchanged across that edge and ordering preserved.
- Reset mid-frame:
  - Stimulus: assert `i_reset_n`=0 during data bit 3 with 2 bytes queued.
  - Required next clock: `o_tx`=1, `o_tx_active`=0, `o_fifo_count`=0, `o_tx_ready`=1.
  - After release, a new 0xFF transmits correctly.
- Idle stability:
  - Stimulus: no writes for 1000 clocks after reset.
  - Required: `o_tx` constantly 1, `o_tx_active` constantly 0.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a small byte FIFO in front of it.
// Bytes arrive over a valid/ready handshake, are queued, and are shifted out
// LSB first with one bit lasting BAUD_MULT clocks. Back-to-back frames are
// sent with no idle gap when the FIFO still holds data at the end of a stop bit.
module uart_tx #(
  parameter int BAUD_MULT       = 139,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     i_uart_clk,
  input  logic                     i_reset_n,
  input  logic [7:0]               i_tx_data,
  input  logic                     i_tx_valid,
  output logic                     o_tx_ready,
  output logic                     o_tx,
  output logic                     o_tx_active,
  output logic [FIFO_DEPTH_LOG2:0] o_fifo_count,
  output logic                     o_dbg_state
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = $clog2(BAUD_MULT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_MULT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND_START = 2'd1,
    SEND_DATA  = 2'd2,
    SEND_STOP  = 2'd3
  } state_t;

  state_t                     state, state_next;
  logic [CNT_W-1:0]           baud_cnt, baud_cnt_next;
  logic [2:0]                 bit_cnt, bit_cnt_next;
  logic [7:0]                 shift, shift_next;
  logic                       tx_next;
  logic                       active_next;
  logic                       baud_done;
  logic                       push;
  logic                       pop;
  logic                       fifo_empty;
  logic [7:0]                 fifo_head;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;

  // Handshake and FIFO status are decoded straight from the registered count
  // so that a pop can never open a write slot in the same cycle.
  assign o_tx_ready  = (o_fifo_count != FIFO_FULL);
  assign push        = i_tx_valid && o_tx_ready;
  assign fifo_empty  = (o_fifo_count == '0);
  assign fifo_head   = mem[rd_ptr];
  assign baud_done   = (baud_cnt == BAUD_LAST);
  assign o_dbg_state = (state == IDLE);

  // Next-state and next-output logic for the frame sequencer; the next line
  // level is computed here so the serial output itself stays registered.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    tx_next       = o_tx;
    active_next   = o_tx_active;
    pop           = 1'b0;

    case (state)
      IDLE: begin
        tx_next     = 1'b1;
        active_next = 1'b0;
        if (!fifo_empty) begin
          pop           = 1'b1;
          shift_next    = fifo_head;
          baud_cnt_next = '0;
          tx_next       = 1'b0;
          active_next   = 1'b1;
          state_next    = SEND_START;
        end
      end

      SEND_START: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          tx_next       = shift[0];
          state_next    = SEND_DATA;
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end

      SEND_DATA: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            tx_next    = 1'b1;
            state_next = SEND_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            tx_next      = shift[1];
          end
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end

      SEND_STOP: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_head;
            tx_next    = 1'b0;
            state_next = SEND_START;
          end else begin
            tx_next     = 1'b1;
            active_next = 1'b0;
            state_next  = IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_next    = IDLE;
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
        tx_next       = 1'b1;
        active_next   = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset abandons any frame and returns the line high.
  always_ff @(posedge i_uart_clk) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      o_tx        <= 1'b1;
      o_tx_active <= 1'b0;
    end else begin
      state       <= state_next;
      baud_cnt    <= baud_cnt_next;
      bit_cnt     <= bit_cnt_next;
      shift       <= shift_next;
      o_tx        <= tx_next;
      o_tx_active <= active_next;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge i_uart_clk) begin
    if (!i_reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   o_fifo_count <= o_fifo_count + 1'b1;
        2'b01:   o_fifo_count <= o_fifo_count - 1'b1;
        default: o_fifo_count <= o_fifo_count;
      endcase
    end
  end

  // FIFO storage; data needs no reset because the pointers define validity.
  always_ff @(posedge i_uart_clk) begin
    if (i_reset_n && push) begin
      mem[wr_ptr] <= i_tx_data;
    end
  end

endmodule
